loop_ctrl: RTL and testbench

Loop-control unit for the brainfuck core. It decodes `[` and `]` from the instruction stream and drives push/pop on the return-address stack. It issues program-counter reloads for backward jumps and suppresses execution while scanning forward past a loop whose entry cell is zero. It sits between the instruction decoder/PC and the return-address stack, and is the only initiator of that stack's requests.

---
 rtl/loop_ctrl.sv | 174 +++++++++++++++++
 tb/tb_loop_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/loop_ctrl.sv
// loop_ctrl: bracket loop-control unit for the brainfuck core.
// Decodes '[' and ']' from the instruction stream and drives the return-address
// stack. It also issues PC reloads for backward jumps, and suppresses execution
// while scanning forward past a loop whose entry cell is zero.
//
// Ports:
//   clk, reset          - rising-edge clock, asynchronous active-high reset
//   instr_valid, instr  - instruction handshake and ASCII byte
//   pc                  - address of the presented instruction
//   cell_zero           - current data cell equals 0
//   stack_top           - current top of the return-address stack
//   push, pop           - combinational stack requests, committed at the edge
//   stack_dout          - push data (the presented pc)
//   pc_load, pc_target  - registered PC reload request and destination
//   skip                - registered: presented instruction must not execute
//   busy                - registered: no instruction accepted this cycle
//   depth               - number of live stack entries
//   error               - sticky fault flag, cleared only by reset
module loop_ctrl #(
  parameter int unsigned pcSize    = 8,
  parameter int unsigned depthSize = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 instr_valid,
  input  logic [7:0]           instr,
  input  logic [pcSize-1:0]    pc,
  input  logic                 cell_zero,
  input  logic [pcSize-1:0]    stack_top,
  output logic                 push,
  output logic                 pop,
  output logic [pcSize-1:0]    stack_dout,
  output logic                 pc_load,
  output logic [pcSize-1:0]    pc_target,
  output logic                 skip,
  output logic                 busy,
  output logic [depthSize:0]   depth,
  output logic                 error
);

  localparam logic [7:0] CH_OPEN  = 8'h5B;
  localparam logic [7:0] CH_CLOSE = 8'h5D;

  localparam logic [depthSize:0]   DEPTH_FULL = {1'b1, {depthSize{1'b0}}};
  localparam logic [depthSize:0]   DEPTH_ONE  = {{depthSize{1'b0}}, 1'b1};
  localparam logic [depthSize-1:0] NEST_ONE   = {{(depthSize-1){1'b0}}, 1'b1};
  localparam logic [pcSize-1:0]    PC_ONE     = {{(pcSize-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_SKIP  = 2'd1,
    S_JUMP  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t               state;
  logic [depthSize-1:0] nest;

  logic accept;
  logic is_open;
  logic is_close;
  logic full;
  logic empty;

  // Instruction decode and stack occupancy flags.
  assign accept   = instr_valid && !busy;
  assign is_open  = (instr == CH_OPEN);
  assign is_close = (instr == CH_CLOSE);
  assign full     = (depth == DEPTH_FULL);
  assign empty    = (depth == '0);

  // Push data is the address of the '[' itself; the jump adds one later.
  assign stack_dout = pc;

  // Stack requests are combinational so the stack commits at the same edge
  // that depth changes; faulting brackets never reach the stack.
  always_comb begin
    push = 1'b0;
    pop  = 1'b0;
    if (!reset && (state == S_RUN) && accept) begin
      if (is_open && !cell_zero && !full) begin
        push = 1'b1;
      end
      if (is_close && cell_zero && !empty) begin
        pop = 1'b1;
      end
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_RUN;
      nest      <= '0;
      depth     <= '0;
      pc_load   <= 1'b0;
      pc_target <= '0;
      skip      <= 1'b0;
      busy      <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (accept && is_open) begin
            if (!cell_zero) begin
              if (full) begin
                state <= S_ERROR;
                busy  <= 1'b1;
                error <= 1'b1;
              end else begin
                depth <= depth + DEPTH_ONE;
              end
            end else begin
              // Entry cell is zero: scan forward to the matching ']'.
              nest  <= NEST_ONE;
              skip  <= 1'b1;
              state <= S_SKIP;
            end
          end else if (accept && is_close) begin
            if (empty) begin
              state <= S_ERROR;
              busy  <= 1'b1;
              error <= 1'b1;
            end else if (!cell_zero) begin
              // Loop again: resume just after the matching '[', frame stays live.
              pc_target <= stack_top + PC_ONE;
              pc_load   <= 1'b1;
              busy      <= 1'b1;
              state     <= S_JUMP;
            end else begin
              depth <= depth - DEPTH_ONE;
            end
          end
        end

        S_SKIP: begin
          if (accept && is_open) begin
            if (&nest) begin
              state <= S_ERROR;
              skip  <= 1'b0;
              busy  <= 1'b1;
              error <= 1'b1;
            end else begin
              nest <= nest + NEST_ONE;
            end
          end else if (accept && is_close) begin
            nest <= nest - NEST_ONE;
            // The matching ']' is itself skipped; skip drops the cycle after.
            if (nest == NEST_ONE) begin
              skip  <= 1'b0;
              state <= S_RUN;
            end
          end
        end

        S_JUMP: begin
          pc_load <= 1'b0;
          busy    <= 1'b0;
          state   <= S_RUN;
        end

        S_ERROR: begin
          busy  <= 1'b1;
          error <= 1'b1;
        end

        default: begin
          state <= S_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_loop_ctrl.sv
// Testbench for loop_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based reference.
module tb_loop_ctrl;

  localparam int unsigned PW       = 8;
  localparam int unsigned DW       = 2;
  localparam int          CAP      = 4;   // 2**DW stack entries
  localparam int          NEST_MAX = 3;   // all-ones nest counter

  localparam logic [7:0] OPEN  = 8'h5B;
  localparam logic [7:0] CLOSE = 8'h5D;
  localparam logic [7:0] PLUS  = 8'h2B;
  localparam logic [7:0] MINUS = 8'h2D;
  localparam logic [7:0] GT    = 8'h3E;

  localparam int M_RUN  = 0;
  localparam int M_SKIP = 1;
  localparam int M_JUMP = 2;
  localparam int M_ERR  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          instr_valid;
  logic [7:0]    instr;
  logic [PW-1:0] pc;
  logic          cell_zero;
  logic [PW-1:0] stack_top;
  logic          push;
  logic          pop;
  logic [PW-1:0] stack_dout;
  logic          pc_load;
  logic [PW-1:0] pc_target;
  logic          skip;
  logic          busy;
  logic [DW:0]   depth;
  logic          error;

  always #5 clk = ~clk;

  loop_ctrl #(.pcSize(PW), .depthSize(DW)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .pc(pc), .cell_zero(cell_zero), .stack_top(stack_top), .push(push),
    .pop(pop), .stack_dout(stack_dout), .pc_load(pc_load),
    .pc_target(pc_target), .skip(skip), .busy(busy), .depth(depth),
    .error(error)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode, nest count, jump target and the stack as a queue.
  int            m_mode = M_RUN;
  int            m_nest = 0;
  logic [PW-1:0] m_target = '0;
  logic [PW-1:0] m_q[$];

  logic acc, is_op, is_cl, e_push, e_pop;

  // Compare DUT against the model mid-cycle, then advance the model.
  always @(negedge clk) begin
    #2;
    if (reset) begin
      chk("rst_push", 32'(push), 32'd0);
      chk("rst_pop", 32'(pop), 32'd0);
      chk("rst_pc_load", 32'(pc_load), 32'd0);
      chk("rst_pc_target", 32'(pc_target), 32'd0);
      chk("rst_skip", 32'(skip), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_depth", 32'(depth), 32'd0);
      m_mode   = M_RUN;
      m_nest   = 0;
      m_target = '0;
      m_q.delete();
    end else begin
      acc    = instr_valid && !(m_mode == M_JUMP || m_mode == M_ERR);
      is_op  = (instr == OPEN);
      is_cl  = (instr == CLOSE);
      e_push = (m_mode == M_RUN) && acc && is_op && !cell_zero && (m_q.size() < CAP);
      e_pop  = (m_mode == M_RUN) && acc && is_cl && cell_zero && (m_q.size() > 0);
      chk("push", 32'(push), 32'(e_push));
      chk("pop", 32'(pop), 32'(e_pop));
      chk("stack_dout", 32'(stack_dout), 32'(pc));
      chk("pc_load", 32'(pc_load), 32'(m_mode == M_JUMP));
      chk("pc_target", 32'(pc_target), 32'(m_target));
      chk("skip", 32'(skip), 32'(m_mode == M_SKIP));
      chk("busy", 32'(busy), 32'(m_mode == M_JUMP || m_mode == M_ERR));
      chk("error", 32'(error), 32'(m_mode == M_ERR));
      chk("depth", 32'(depth), 32'(m_q.size()));

      if (m_mode == M_JUMP) begin
        m_mode = M_RUN;
      end else if (acc && m_mode == M_RUN) begin
        if (is_op) begin
          if (!cell_zero) begin
            if (m_q.size() == CAP) m_mode = M_ERR;
            else m_q.push_back(pc);
          end else begin
            m_nest = 1;
            m_mode = M_SKIP;
          end
        end else if (is_cl) begin
          if (m_q.size() == 0) m_mode = M_ERR;
          else if (!cell_zero) begin
            m_target = m_q[$] + PW'(1);
            m_mode   = M_JUMP;
          end else begin
            void'(m_q.pop_back());
          end
        end
      end else if (acc && m_mode == M_SKIP) begin
        if (is_op) begin
          if (m_nest == NEST_MAX) m_mode = M_ERR;
          else m_nest++;
        end else if (is_cl) begin
          m_nest--;
          if (m_nest == 0) m_mode = M_RUN;
        end
      end
    end
  end

  // Drive one cycle of inputs at the falling edge; stack_top follows the model stack.
  task automatic drive(input logic rst, input logic v, input logic [7:0] ch,
                       input logic cz, input logic [PW-1:0] p);
    @(negedge clk);
    reset       = rst;
    instr_valid = v;
    instr       = ch;
    cell_zero   = cz;
    pc          = p;
    stack_top   = (m_q.size() > 0) ? m_q[$] : PW'($urandom);
  endtask

  logic [7:0] seq [5];
  logic [7:0] rch;
  logic       rrst;

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr = '0; cell_zero = 1'b0;
    pc = '0; stack_top = '0;

    // Reset state
    drive(1, 0, 8'h00, 0, 0); #3;
    chk("lit_reset_depth", 32'(depth), 32'd0);
    chk("lit_reset_busy", 32'(busy), 32'd0);
    chk("lit_reset_error", 32'(error), 32'd0);

    // Push
    drive(0, 1, OPEN, 0, 8'd5); #3;
    chk("lit_push", 32'(push), 32'd1);
    chk("lit_push_dout", 32'(stack_dout), 32'd5);
    drive(0, 0, 8'h00, 0, 0); #3;
    chk("lit_push_depth", 32'(depth), 32'd1);

    // Backward jump
    drive(0, 1, CLOSE, 0, 8'd9); #3;
    chk("lit_jump_nopop", 32'(pop), 32'd0);
    drive(0, 0, 8'h00, 0, 0); #3;
    chk("lit_jump_load", 32'(pc_load), 32'd1);
    chk("lit_jump_target", 32'(pc_target), 32'd6);
    chk("lit_jump_busy", 32'(busy), 32'd1);
    chk("lit_jump_depth", 32'(depth), 32'd1);
    drive(0, 1, PLUS, 0, 8'd6); #3;
    chk("lit_jump_done", 32'(pc_load), 32'd0);
    drive(0, 1, CLOSE, 1, 8'd9); #3;
    chk("lit_pop", 32'(pop), 32'd1);
    drive(0, 0, 8'h00, 0, 0); #3;
    chk("lit_pop_depth", 32'(depth), 32'd0);

    // Nested forward skip
    drive(0, 1, OPEN, 1, 8'd20); #3;
    chk("lit_skip_entry_nopush", 32'(push), 32'd0);
    chk("lit_skip_entry_skip", 32'(skip), 32'd0);
    seq[0] = OPEN; seq[1] = PLUS; seq[2] = CLOSE; seq[3] = MINUS; seq[4] = CLOSE;
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, seq[i], 0, PW'(21 + i)); #3;
      chk("lit_skip_on", 32'(skip), 32'd1);
      chk("lit_skip_stack", 32'({push, pop}), 32'd0);
    end
    drive(0, 1, GT, 0, 8'd26); #3;
    chk("lit_skip_off", 32'(skip), 32'd0);
    chk("lit_skip_depth", 32'(depth), 32'd0);

    // Underflow, then asynchronous clear of error
    drive(1, 0, 8'h00, 0, 0);
    drive(0, 1, CLOSE, 0, 8'd30); #3;
    chk("lit_uflow_nopop", 32'(pop), 32'd0);
    drive(0, 0, 8'h00, 0, 0); #3;
    chk("lit_uflow_error", 32'(error), 32'd1);
    chk("lit_uflow_busy", 32'(busy), 32'd1);
    drive(0, 1, OPEN, 0, 8'd31); #3;
    chk("lit_uflow_nopush", 32'(push), 32'd0);
    reset = 1'b1; #1;
    chk("lit_uflow_async_clear", 32'(error), 32'd0);
    drive(1, 0, 8'h00, 0, 0);

    // Overflow with a 4-entry stack
    for (int i = 1; i <= 4; i++) begin
      drive(0, 1, OPEN, 0, PW'(i)); #3;
      chk("lit_oflow_fill", 32'(push), 32'd1);
    end
    drive(0, 1, OPEN, 0, 8'd5); #3;
    chk("lit_oflow_nopush", 32'(push), 32'd0);
    drive(0, 0, 8'h00, 0, 0); #3;
    chk("lit_oflow_error", 32'(error), 32'd1);
    chk("lit_oflow_depth", 32'(depth), 32'd4);
    drive(1, 0, 8'h00, 0, 0);

    // Reset in the pc_load cycle
    drive(0, 1, OPEN, 0, 8'd40);
    drive(0, 1, CLOSE, 0, 8'd50);
    drive(0, 0, 8'h00, 0, 0); #3;
    chk("lit_rj_load", 32'(pc_load), 32'd1);
    chk("lit_rj_target", 32'(pc_target), 32'd41);
    reset = 1'b1; #1;
    chk("lit_rj_load_clr", 32'(pc_load), 32'd0);
    chk("lit_rj_busy_clr", 32'(busy), 32'd0);
    chk("lit_rj_depth_clr", 32'(depth), 32'd0);
    drive(1, 0, 8'h00, 0, 0);
    drive(0, 1, OPEN, 0, 8'd60); #3;
    chk("lit_rj_push", 32'(push), 32'd1);
    drive(0, 0, 8'h00, 0, 0); #3;
    chk("lit_rj_depth", 32'(depth), 32'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if (m_mode == M_ERR) rrst = ($urandom_range(0, 7) == 0);
      else                 rrst = ($urandom_range(0, 199) == 0);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: rch = OPEN;
        4, 5, 6:    rch = CLOSE;
        7:          rch = PLUS;
        8:          rch = MINUS;
        default:    rch = GT;
      endcase
      drive(rrst, ($urandom_range(0, 9) < 8), rch, 1'($urandom_range(0, 1)),
            PW'($urandom));
    end

    drive(1, 0, 8'h00, 0, 0);
    drive(1, 0, 8'h00, 0, 0);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
